// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, pairs each registered-memory word with
// its address, and supports stall hold-over, redirect squash and fetch counting.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_reg_q, pc_reg_d;
  logic [31:0] pc_d1_q, pc_d1_d;
  logic        valid_d1_q, valid_d1_d;
  logic        held_q, held_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        accept;

  assign accept = valid_d1_q & ~stall;

  always_comb begin
    pc_reg_d      = pc_reg_q;
    pc_d1_d       = pc_d1_q;
    valid_d1_d    = valid_d1_q;
    held_d        = held_q;
    hold_instr_d  = hold_instr_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      // Redirect beats stall: the in-flight word is dropped, the delivered one may still retire.
      pc_reg_d      = {redirect_pc[31:2], 2'b00};
      valid_d1_d    = 1'b0;
      held_d        = 1'b0;
      fetch_count_d = fetch_count_q + {31'd0, accept};
    end else if (stall) begin
      // Memory keeps re-reading pc_reg while stalled, so capture the delivered word once.
      if (!held_q) begin
        hold_instr_d = imem_instr;
        held_d       = 1'b1;
      end
    end else begin
      pc_d1_d       = pc_reg_q;
      valid_d1_d    = 1'b1;
      pc_reg_d      = pc_reg_q + 32'd4;
      held_d        = 1'b0;
      fetch_count_d = fetch_count_q + {31'd0, valid_d1_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg_q      <= RESET_PC;
      pc_d1_q       <= 32'd0;
      valid_d1_q    <= 1'b0;
      held_q        <= 1'b0;
      hold_instr_q  <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_reg_q      <= pc_reg_d;
      pc_d1_q       <= pc_d1_d;
      valid_d1_q    <= valid_d1_d;
      held_q        <= held_d;
      hold_instr_q  <= hold_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_pc     = pc_reg_q;
  assign if_valid    = valid_d1_q;
  assign if_pc       = pc_d1_q;
  assign if_pc_plus4 = pc_d1_q + 32'd4;
  assign if_instr    = valid_d1_q ? (held_q ? hold_instr_q : imem_instr) : 32'd0;
  assign fetch_count = fetch_count_q;

endmodule
